// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : mem_arb_pkg                                                  |
// | Description : Shared constants for the memory arbiter: one-hot FSM state   |
// |               encodings and requester port identifiers.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mem_arb_pkg;

   localparam int ST_W = 4;

   // One-hot state encodings
   localparam logic [ST_W-1:0] ST_IDLE   = 4'b0001;
   localparam logic [ST_W-1:0] ST_ACCESS = 4'b0010;
   localparam logic [ST_W-1:0] ST_RESP   = 4'b0100;
   localparam logic [ST_W-1:0] ST_ABORT  = 4'b1000;

   // Requester identifiers; also the bit index into the request vector
   localparam logic PORT_F = 1'b0;
   localparam logic PORT_D = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : mem_arbiter_if                                               |
// | Description : Bundles the fetch port (F), data port (D), response and      |
// |               memory-side signals of the memory arbiter.                   |
// |   master : arbiter view  (drives rdy/rdata/err/busy and memory command)    |
// |   slave  : environment view (requesters and memory)                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface mem_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   // Fetch port (read-only)
   logic              f_req;
   logic [ADDR_W-1:0] f_addr;
   logic              f_rdy;
   // Data port (read/write)
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_rdy;
   // Shared response / status
   logic [DATA_W-1:0] rdata;
   logic              err;
   logic              busy;
   // Memory side
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
      output f_rdy, d_rdy, rdata, err, busy, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
      input  f_rdy, d_rdy, rdata, err, busy, mem_req, mem_we, mem_addr, mem_wdata
   );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_arb_rr2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : arb_rr2                                                      |
// | Description : Combinational 2-way round-robin picker.                      |
// |   req[1:0] in  : request vector, bit index = port id                       |
// |   last     in  : id of the port served most recently                       |
// |   grant    out : id of the winning port (valid only when valid = 1)        |
// |   valid    out : at least one request present                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
import mem_arb_pkg::*;

module arb_rr2 (
   input  wire logic [1:0] req,
   input  wire logic       last,
   output logic            grant,
   output logic            valid
);

   always_comb begin
      valid = |req;
      grant = PORT_F;
      if (req[PORT_F] && req[PORT_D]) begin
         // Contention: the port not served last wins
         grant = ~last;
      end else if (req[PORT_D]) begin
         grant = PORT_D;
      end else begin
         grant = PORT_F;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_arbiter                                                  |
// | Description : Shares one single-port memory between a read-only fetch      |
// |               requester (F) and a read/write data requester (D). A 2-way   |
// |               round-robin picks the winner, its command is latched and a   |
// |               4-state FSM runs the memory handshake, returning read data   |
// |               with a one-cycle rdy pulse to the winner.                    |
// | Ports       : clk, rst (async, active-high), bus (mem_arbiter_if.master:   |
// |               f_*/d_* requester ports, rdata/err/busy, mem_* memory side)  |
// | Option      : MEM_ARB_TIMEOUT_EN - abort an access after TIMEOUT cycles    |
// |               without mem_ack, returning rdy with err and rdata = 0.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
import mem_arb_pkg::*;

module mem_arbiter #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 15
) (
   input  wire logic      clk,
   input  wire logic      rst,
   mem_arbiter_if.master  bus
);

   if (TIMEOUT < 1) begin : g_timeout_check
      $error("mem_arbiter: TIMEOUT must be at least 1");
   end

   logic [ST_W-1:0]   state_q, state_d;
   logic              win_q, win_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              last_q, last_d;

   logic              w_arb_grant;
   logic              w_arb_valid;
   logic              w_done;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

   arb_rr2 u_arb (
      .req   ({bus.d_req, bus.f_req}),
      .last  (last_q),
      .grant (w_arb_grant),
      .valid (w_arb_valid)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Command, response and pointer registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_q   <= PORT_F;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         // "Last served = D" makes F the favoured port after reset
         last_q  <= PORT_D;
`ifdef MEM_ARB_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         win_q   <= win_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         last_q  <= last_d;
`ifdef MEM_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   // Next-state and register-update logic
   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      last_d  = last_q;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (w_arb_valid) begin
               win_d   = w_arb_grant;
               state_d = ST_ACCESS;
               if (w_arb_grant == PORT_D) begin
                  addr_d  = bus.d_addr;
                  we_d    = bus.d_we;
                  wdata_d = bus.d_wdata;
               end else begin
                  addr_d  = bus.f_addr;
                  we_d    = 1'b0;
                  wdata_d = '0;
               end
`ifdef MEM_ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         ST_ACCESS: begin
            // An ack in the same cycle as the timeout limit takes precedence
            if (bus.mem_ack) begin
               rdata_d = bus.mem_rdata;
               state_d = ST_RESP;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               rdata_d = '0;
               state_d = ST_ABORT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         ST_RESP: begin
            last_d  = win_q;
            state_d = ST_IDLE;
         end
`ifdef MEM_ARB_TIMEOUT_EN
         ST_ABORT: begin
            last_d  = win_q;
            state_d = ST_IDLE;
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs are decoded from registered state only
   always_comb begin
`ifdef MEM_ARB_TIMEOUT_EN
      w_done      = (state_q == ST_RESP) || (state_q == ST_ABORT);
      bus.err     = (state_q == ST_ABORT);
`else
      w_done      = (state_q == ST_RESP);
      bus.err     = 1'b0;
`endif
      bus.f_rdy     = w_done && (win_q == PORT_F);
      bus.d_rdy     = w_done && (win_q == PORT_D);
      bus.busy      = (state_q != ST_IDLE);
      bus.mem_req   = (state_q == ST_ACCESS);
      bus.mem_we    = we_q;
      bus.mem_addr  = addr_q;
      bus.mem_wdata = wdata_q;
      bus.rdata     = rdata_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_arbiter                                               |
// | Description : Directed self-checking bench for mem_arbiter. Each scenario  |
// |               task drives the requesters and plays the memory by hand.     |
// |               Define MEM_ARB_TIMEOUT_EN to exercise the abort path.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;

   logic clk = 1'b0;
   logic rst;
   int   passed = 0;
   int   total  = 0;

   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(15)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      bus.f_req     = 1'b0;
      bus.f_addr    = '0;
      bus.d_req     = 1'b0;
      bus.d_we      = 1'b0;
      bus.d_addr    = '0;
      bus.d_wdata   = '0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
   endtask

   task automatic apply_reset;
      rst = 1'b1;
      tick();
      #2 rst = 1'b0;
   endtask

   task automatic test_reset;
      idle_inputs();
      rst = 1'b1;
      #3;
      total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else passed++;
      total++; if (bus.mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req); else passed++;
      total++; if ({bus.f_rdy, bus.d_rdy, bus.err} !== 3'b000) $display("FAIL reset_rdy_err: got %b expected 000", {bus.f_rdy, bus.d_rdy, bus.err}); else passed++;
      total++; if (bus.rdata !== 16'h0000) $display("FAIL reset_rdata: got %h expected 0000", bus.rdata); else passed++;
      total++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 25'd0) $display("FAIL reset_mem_cmd: got %h expected 0", {bus.mem_we, bus.mem_addr, bus.mem_wdata}); else passed++;
      tick();
      tick();
      #2 rst = 1'b0;
   endtask

   task automatic test_single_fetch;
      bus.f_req  = 1'b1;
      bus.f_addr = 8'h10;
      tick();
      total++; if (bus.mem_req !== 1'b1) $display("FAIL fetch_mem_req: got %b expected 1", bus.mem_req); else passed++;
      total++; if (bus.mem_addr !== 8'h10) $display("FAIL fetch_mem_addr: got %h expected 10", bus.mem_addr); else passed++;
      total++; if (bus.mem_we !== 1'b0) $display("FAIL fetch_mem_we: got %b expected 0", bus.mem_we); else passed++;
      total++; if (bus.busy !== 1'b1) $display("FAIL fetch_busy: got %b expected 1", bus.busy); else passed++;
      tick();
      tick();
      tick();
      total++; if ({bus.mem_req, bus.f_rdy} !== 2'b10) $display("FAIL fetch_wait: got %b expected 10", {bus.mem_req, bus.f_rdy}); else passed++;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 16'hBEEF;
      tick();
      bus.mem_ack   = 1'b0;
      total++; if (bus.f_rdy !== 1'b1) $display("FAIL fetch_rdy: got %b expected 1", bus.f_rdy); else passed++;
      total++; if (bus.rdata !== 16'hBEEF) $display("FAIL fetch_rdata: got %h expected beef", bus.rdata); else passed++;
      total++; if ({bus.d_rdy, bus.err, bus.mem_req} !== 3'b000) $display("FAIL fetch_resp_misc: got %b expected 000", {bus.d_rdy, bus.err, bus.mem_req}); else passed++;
      bus.f_req = 1'b0;
      tick();
      total++; if ({bus.f_rdy, bus.busy} !== 2'b00) $display("FAIL fetch_single_pulse: got %b expected 00", {bus.f_rdy, bus.busy}); else passed++;
      total++; if (bus.rdata !== 16'hBEEF) $display("FAIL fetch_rdata_hold: got %h expected beef", bus.rdata); else passed++;
   endtask

   task automatic test_data_write;
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b1;
      bus.d_addr  = 8'h22;
      bus.d_wdata = 16'h1234;
      tick();
      total++; if (bus.mem_we !== 1'b1) $display("FAIL write_mem_we: got %b expected 1", bus.mem_we); else passed++;
      total++; if (bus.mem_wdata !== 16'h1234) $display("FAIL write_mem_wdata: got %h expected 1234", bus.mem_wdata); else passed++;
      total++; if (bus.mem_addr !== 8'h22) $display("FAIL write_mem_addr: got %h expected 22", bus.mem_addr); else passed++;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 16'h0000;
      tick();
      bus.mem_ack = 1'b0;
      total++; if ({bus.d_rdy, bus.f_rdy} !== 2'b10) $display("FAIL write_rdy: got %b expected 10", {bus.d_rdy, bus.f_rdy}); else passed++;
      bus.d_req = 1'b0;
      bus.d_we  = 1'b0;
      tick();
      total++; if ({bus.d_rdy, bus.f_rdy, bus.busy} !== 3'b000) $display("FAIL write_after: got %b expected 000", {bus.d_rdy, bus.f_rdy, bus.busy}); else passed++;
   endtask

   task automatic test_contention;
      apply_reset();
      bus.f_req  = 1'b1;
      bus.f_addr = 8'h30;
      bus.d_req  = 1'b1;
      bus.d_we   = 1'b0;
      bus.d_addr = 8'h40;
      for (int i = 0; i < 4; i++) begin
         bit            exp_d;
         logic [7:0]    exp_addr;
         logic [15:0]   exp_data;
         exp_d    = (i % 2) == 1;
         exp_addr = exp_d ? 8'h40 : 8'h30;
         exp_data = 16'h1000 + 16'(i);
         tick();
         total++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, exp_addr}) $display("FAIL contention_grant%0d: got req=%b addr=%h expected req=1 addr=%h", i, bus.mem_req, bus.mem_addr, exp_addr); else passed++;
         bus.mem_ack   = 1'b1;
         bus.mem_rdata = exp_data;
         tick();
         bus.mem_ack = 1'b0;
         total++; if ({bus.f_rdy, bus.d_rdy} !== {~exp_d, exp_d}) $display("FAIL contention_rdy%0d: got f=%b d=%b expected f=%b d=%b", i, bus.f_rdy, bus.d_rdy, ~exp_d, exp_d); else passed++;
         total++; if (bus.rdata !== exp_data) $display("FAIL contention_rdata%0d: got %h expected %h", i, bus.rdata, exp_data); else passed++;
         tick();
      end
      bus.f_req = 1'b0;
      bus.d_req = 1'b0;
      tick();
   endtask

   task automatic test_async_reset;
      // Complete an F access so the pointer points at F before the reset
      bus.f_req  = 1'b1;
      bus.f_addr = 8'h50;
      tick();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 16'h0F0F;
      tick();
      bus.mem_ack = 1'b0;
      bus.f_req   = 1'b0;
      tick();
      bus.d_req  = 1'b1;
      bus.d_addr = 8'h60;
      tick();
      total++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 8'h60}) $display("FAIL areset_pre: got req=%b addr=%h expected req=1 addr=60", bus.mem_req, bus.mem_addr); else passed++;
      #3 rst = 1'b1;
      #1;
      total++; if ({bus.mem_req, bus.busy} !== 2'b00) $display("FAIL areset_immediate: got %b expected 00", {bus.mem_req, bus.busy}); else passed++;
      @(posedge clk);
      #1;
      total++; if ({bus.f_rdy, bus.d_rdy, bus.busy} !== 3'b000) $display("FAIL areset_no_rdy: got %b expected 000", {bus.f_rdy, bus.d_rdy, bus.busy}); else passed++;
      #2 rst = 1'b0;
      bus.f_req = 1'b1;
      tick();
      total++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 8'h50}) $display("FAIL areset_next_grant: got req=%b addr=%h expected req=1 addr=50", bus.mem_req, bus.mem_addr); else passed++;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 16'h5A5A;
      tick();
      bus.mem_ack = 1'b0;
      total++; if ({bus.f_rdy, bus.d_rdy} !== 2'b10) $display("FAIL areset_complete: got %b expected 10", {bus.f_rdy, bus.d_rdy}); else passed++;
      bus.f_req = 1'b0;
      bus.d_req = 1'b0;
      tick();
   endtask

   task automatic test_spurious_ack;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 16'hFFFF;
      tick();
      total++; if ({bus.busy, bus.f_rdy, bus.d_rdy} !== 3'b000) $display("FAIL spurious_state: got %b expected 000", {bus.busy, bus.f_rdy, bus.d_rdy}); else passed++;
      tick();
      total++; if ({bus.busy, bus.f_rdy, bus.d_rdy} !== 3'b000) $display("FAIL spurious_state2: got %b expected 000", {bus.busy, bus.f_rdy, bus.d_rdy}); else passed++;
      total++; if (bus.rdata !== 16'h5A5A) $display("FAIL spurious_rdata: got %h expected 5a5a", bus.rdata); else passed++;
      bus.mem_ack = 1'b0;
      tick();
   endtask

   task automatic test_timeout;
`ifdef MEM_ARB_TIMEOUT_EN
      bus.f_req  = 1'b1;
      bus.f_addr = 8'h70;
      tick();
      // ACCESS cycles 2..15 still waiting
      for (int i = 2; i <= 15; i++) begin
         tick();
         total++; if ({bus.mem_req, bus.f_rdy, bus.err} !== 3'b100) $display("FAIL timeout_wait%0d: got %b expected 100", i, {bus.mem_req, bus.f_rdy, bus.err}); else passed++;
      end
      tick();
      total++; if ({bus.f_rdy, bus.d_rdy, bus.err} !== 3'b101) $display("FAIL timeout_abort: got %b expected 101", {bus.f_rdy, bus.d_rdy, bus.err}); else passed++;
      total++; if ({bus.mem_req, bus.rdata} !== 17'd0) $display("FAIL timeout_abort_data: got req=%b rdata=%h expected req=0 rdata=0000", bus.mem_req, bus.rdata); else passed++;
      bus.f_req = 1'b0;
      tick();
      total++; if ({bus.busy, bus.err, bus.f_rdy} !== 3'b000) $display("FAIL timeout_idle: got %b expected 000", {bus.busy, bus.err, bus.f_rdy}); else passed++;
      bus.d_req  = 1'b1;
      bus.d_addr = 8'h71;
      tick();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 16'h1111;
      tick();
      bus.mem_ack = 1'b0;
      total++; if ({bus.d_rdy, bus.err, bus.rdata} !== {2'b10, 16'h1111}) $display("FAIL timeout_recover: got d_rdy=%b err=%b rdata=%h expected 1 0 1111", bus.d_rdy, bus.err, bus.rdata); else passed++;
      bus.d_req = 1'b0;
      tick();
      // Ack arriving in the 15th ACCESS cycle wins over the abort
      bus.f_req = 1'b1;
      tick();
      for (int i = 2; i <= 15; i++) tick();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 16'h2222;
      tick();
      bus.mem_ack = 1'b0;
      total++; if ({bus.f_rdy, bus.err, bus.rdata} !== {2'b10, 16'h2222}) $display("FAIL timeout_ack_wins: got f_rdy=%b err=%b rdata=%h expected 1 0 2222", bus.f_rdy, bus.err, bus.rdata); else passed++;
      bus.f_req = 1'b0;
      tick();
`else
      bus.f_req  = 1'b1;
      bus.f_addr = 8'h70;
      tick();
      repeat (20) tick();
      total++; if ({bus.mem_req, bus.busy, bus.f_rdy, bus.err} !== 4'b1100) $display("FAIL notimeout_wait: got %b expected 1100", {bus.mem_req, bus.busy, bus.f_rdy, bus.err}); else passed++;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 16'h3333;
      tick();
      bus.mem_ack = 1'b0;
      total++; if ({bus.f_rdy, bus.err, bus.rdata} !== {2'b10, 16'h3333}) $display("FAIL notimeout_complete: got f_rdy=%b err=%b rdata=%h expected 1 0 3333", bus.f_rdy, bus.err, bus.rdata); else passed++;
      bus.f_req = 1'b0;
      tick();
`endif
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_data_write();
      test_contention();
      test_async_reset();
      test_spurious_ack();
      test_timeout();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-port memory between the instruction-fetch requester (port F, read-only) and the data-move requester (port D, read/write). A 2-way round-robin picks the winner and latches its command. A 4-state FSM drives the memory handshake and returns read data with a one-cycle ready pulse to the winner. The block sits between the CPU control/datapath and the memory, and produces the per-port ready strobes the control FSM waits on.

Parameters:
ADDR_W, 8, address width in bits
DATA_W, 16, data width in bits
TIMEOUT, 15, maximum ACCESS cycles without mem_ack before abort (used only with the optional feature)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  reset, asynchronous, active-high
f_req  in  1  fetch request, held until f_rdy
f_addr  in  ADDR_W  fetch address
f_rdy  out  1  one-cycle fetch completion pulse
d_req  in  1  data request, held until d_rdy
d_we  in  1  data write enable (1 = write)
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  data write value
d_rdy  out  1  one-cycle data completion pulse
rdata  out  DATA_W  read data; valid while f_rdy or d_rdy is high
err  out  1  timeout flag, pulsed with rdy
busy  out  1  high in any state except IDLE
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ack  in  1  memory completion, single-cycle
mem_rdata  in  DATA_W  memory read data, valid with mem_ack

Behaviour:
- Reset (asynchronous): state = IDLE.
  - All outputs 0; rdata = 0.
  - Internal command registers 0.
  - Priority pointer favours F.
  - Reset mid-transaction abandons it; no rdy pulse is issued.
- States: IDLE, ACCESS, RESP, and ABORT (ABORT is reachable only with the optional feature).
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: that port wins.
  - Both reqs: the port not served last wins (pointer).
  - On a win: latch winner id, addr, we (F forces we = 0) and wdata; go to ACCESS.
- ACCESS:
  - mem_req = 1; mem_we, mem_addr and mem_wdata come from the latched registers and are stable.
  - mem_ack = 1: capture mem_rdata into rdata (captured for writes too, value unspecified); go to RESP.
- RESP:
  - Pulse the winner's rdy for exactly 1 cycle.
  - Pointer ← winner.
  - Next state: IDLE.
- Latency: req seen in IDLE at cycle 0 → mem_req at cycle 1 → ack at cycle k ≥ 1 → rdy at k+1. Minimum is 2 cycles.
- The loser is not re-arbitrated until IDLE.
- Back-to-back: the earliest new grant is the IDLE cycle after RESP, so a port gets at most one grant per 3 cycles.
- Requesters drop req on the edge at which they sample rdy. A req still high in IDLE is treated as a new request.
- req deasserted mid-transaction: the transaction still completes and rdy still pulses.
- mem_ack outside ACCESS is ignored.
- rdata holds its value until the next capture.
- f_rdy and d_rdy are never high together.

Optional Feature:
Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entering ACCESS and increments each ACCESS cycle without ack.
  - When the count reaches TIMEOUT with no ack, go to ABORT instead of waiting.
  - ABORT: drop mem_req; pulse the winner's rdy and err together; rdata = 0; pointer updates as in RESP; next state IDLE.
  - An ack in the same cycle the count reaches TIMEOUT wins: normal path, no error.
- Undefined: no counter and no ABORT state; ACCESS waits indefinitely; err is tied 0.

Decomposition:
- Package mem_arb_pkg: state encodings (one-hot localparams for IDLE/ACCESS/RESP/ABORT) and port-id constants PORT_F = 0, PORT_D = 1.
- Sub-module arb_rr2: combinational 2-way round-robin picker (req[1:0], last → grant id, valid). It is reusable by future requesters.
- FSM, command registers and timeout counter stay in mem_arbiter.

Test Plan:
- Single fetch: f_req = 1, f_addr = 0x10, memory acks 3 cycles after mem_req with 0xBEEF → mem_addr = 0x10, mem_we = 0, f_rdy pulses once with rdata = 0xBEEF, err = 0.
- Data write: d_req = 1, d_we = 1, d_addr = 0x22, d_wdata = 0x1234, immediate ack → mem_we = 1, mem_wdata = 0x1234, d_rdy at cycle 2, f_rdy stays 0.
- Contention: f_req and d_req both asserted from reset and held until their rdy → grant order F, D, F, D; each port's addr matches on the memory side.
- Async reset: rst pulsed in ACCESS, asynchronous to the clock edge → mem_req drops immediately, no rdy, next grant goes to F.
- Timeout (macro on, TIMEOUT = 15): mem_ack never asserted → 15 ACCESS cycles, then the winner's rdy = 1 and err = 1, rdata = 0, and the FSM accepts a new req afterwards. With the macro off, the FSM stays in ACCESS.
- Spurious ack: mem_ack = 1 while in IDLE → no state change, no rdy pulse.
